k054539_rom_arb: RTL
====================

Name: k054539_rom_arb

Overview:
Arbiter and sequencer for the 054539 external ROM/RAM bus (RA/RD pins). It shares the single bus between the per-channel sample fetch requests from the voice engine and the host CPU's indirect ROM/RAM access port. It drives the address, strobes and data direction, and generates host WAIT. It sits between the channel sequencer / host register file and the PIN_RA / PIN_RD pads.

Parameters:
NCH, 8, number of voice channel requesters
AW, 24, external address width
ACC_CYC, 4, strobe-active cycles per access (1..15)

Ports:
CLK  in  1  system clock
RES  in  1  asynchronous reset, active high
CH_REQ  in  NCH  per-channel fetch request (read only)
CH_ADDR  in  NCH*AW  per-channel address, channel i at bits [i*AW +: AW]
CH_ACK  out  NCH  one-hot, one-cycle acknowledge; CH_RDATA valid the same cycle
CH_RDATA  out  8  fetched byte
CPU_REQ  in  1  host access request
CPU_WE  in  1  1 = write, 0 = read
CPU_ADDR  in  AW  host address
CPU_WDATA  in  8  host write data
CPU_ACK  out  1  one-cycle acknowledge; CPU_RDATA valid the same cycle
CPU_RDATA  out  8  host read byte
NWAIT  out  1  active-low host wait
RA  out  AW  external address
RD_IN  in  8  external data in
RD_OUT  out  8  external data out
RD_OE  out  1  1 = drive RD_OUT onto pads
NROE  out  1  active-low read strobe
NRWE  out  1  active-low write strobe

Behaviour:
- Reset (async, RES=1): state IDLE; RA=0, RD_OUT=0, RD_OE=0, NROE=1, NRWE=1, CH_ACK=0, CPU_ACK=0, CH_RDATA=0, CPU_RDATA=0, rr pointer=0, cpu_last=0. Reset asserted mid-access aborts it immediately; strobes return high asynchronously; no ack is issued.
- States: IDLE -> ADDR -> ACCESS -> DONE -> IDLE.
- IDLE: no request -> stay. Otherwise, at the clock edge, latch the winner, its address and its write flag/data, then go to ADDR. RA is loaded on that edge.
- Arbitration: if CPU_REQ=1 and (cpu_last=0 or no CH_REQ) -> CPU wins. Otherwise the first channel with CH_REQ set, scanning from rr, rr+1, ... mod NCH, wins. On a channel grant: rr <= winner+1 mod NCH and cpu_last <= 0. On a CPU grant: cpu_last <= 1.
- ADDR: one cycle with RA stable and strobes high (address setup). For a CPU write, RD_OUT is loaded and RD_OE=1 from here.
- ACCESS: counter loaded with ACC_CYC-1 on entry. NROE=0 for reads, NRWE=0 for writes. Leave when counter==0. On the leaving edge, read data is captured from RD_IN into CH_RDATA or CPU_RDATA, and the strobe returns high.
- DONE: one cycle. The granted ack (CH_ACK bit or CPU_ACK) =1, RA held, RD_OE=1 kept for writes. Then go to IDLE and clear RD_OE and the ack.
- Latency: grant edge E; ack is high during the cycle after edge E+1+ACC_CYC. Slot length is ACC_CYC+3 cycles. No grant happens in the DONE cycle.
- Requester rule: REQ and ADDR must be held until ack. If REQ drops mid-access, the access still completes and the ack still pulses; the data is discarded by the requester.
- CH_RDATA / CPU_RDATA hold their value until the next capture for that port.
- NWAIT = ~(CPU_REQ & ~CPU_ACK) (combinational). It is 1 under reset when CPU_REQ=0.
- Simultaneous CPU_REQ and CH_REQ after a channel slot: CPU wins. Back-to-back with channels pending: grants alternate channel / CPU.
- RA wraps naturally at AW bits; no address arithmetic is done here.

Test Plan:
1. Reset, then CH_REQ[2]=1, CH_ADDR[2]=0x123456, RD_IN=0xA5 -> RA=0x123456 after grant edge; NROE low for exactly 4 cycles; CH_ACK=0x04 for one cycle, 5 cycles after the grant edge, with CH_RDATA=0xA5.
2. CH_REQ=0xFF held for 16 slots -> grant order 0,1,...,7,0,...; each channel acked twice; slot spacing 7 cycles.
3. CPU_REQ write, CPU_ADDR=0x000010, CPU_WDATA=0x3C, together with CH_REQ[0] -> CPU served first: RD_OE=1 from ADDR through DONE, RD_OUT=0x3C, NRWE low 4 cycles. Then channel 0 is served. NWAIT low from CPU_REQ until CPU_ACK.
4. CPU_REQ and CH_REQ[5] held continuously -> grants alternate CPU, ch5, CPU, ch5. Neither requester starves.
5. Assert RES during ACCESS of a read -> NROE=1 and all outputs at reset values immediately; no ack. After release, a pending CH_REQ is re-granted from rr=0.
6. ACC_CYC=1 build: single-channel read -> NROE low for 1 cycle; ack 2 cycles after the grant edge; slot of 4 cycles.

Source files
------------

// File: rtl/k054539_rom_arb.sv
// k054539_rom_arb: shares the external ROM/RAM bus (RA/RD pads) between the
// per-channel sample fetchers and the host indirect access port.
// Every access is IDLE -> ADDR -> ACCESS -> DONE, so one slot is ACC_CYC+3 cycles.
module k054539_rom_arb #(
   parameter int NCH     = 8,
   parameter int AW      = 24,
   parameter int ACC_CYC = 4
) (
   input  logic              CLK,
   input  logic              RES,
   input  logic [NCH-1:0]    CH_REQ,
   input  logic [NCH*AW-1:0] CH_ADDR,
   output logic [NCH-1:0]    CH_ACK,
   output logic [7:0]        CH_RDATA,
   input  logic              CPU_REQ,
   input  logic              CPU_WE,
   input  logic [AW-1:0]     CPU_ADDR,
   input  logic [7:0]        CPU_WDATA,
   output logic              CPU_ACK,
   output logic [7:0]        CPU_RDATA,
   output logic              NWAIT,
   output logic [AW-1:0]     RA,
   input  logic [7:0]        RD_IN,
   output logic [7:0]        RD_OUT,
   output logic              RD_OE,
   output logic              NROE,
   output logic              NRWE
);

   localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

   typedef enum logic [1:0] {
      IDLE,
      ADDR,
      ACCESS,
      DONE
   } state_t;

   state_t        r_state;
   state_t        w_nextState;
   logic [CW-1:0] r_rr;
   logic [CW-1:0] r_chSel;
   logic [CW-1:0] w_chWin;
   logic [CW-1:0] w_rrNext;
   logic          w_chAny;
   logic          w_cpuWin;
   logic          r_cpuLast;
   logic          r_isCpu;
   logic          r_isWrite;
   logic [3:0]    r_cnt;
   logic [AW-1:0] r_ra;
   logic [7:0]    r_rdOut;
   logic [7:0]    r_chRdata;
   logic [7:0]    r_cpuRdata;

   // Round-robin scan of the channel requests starting at the rr pointer
   always_comb begin
      int            idxInt;
      logic [CW-1:0] idx;
      w_chAny = 1'b0;
      w_chWin = '0;
      idxInt  = 0;
      idx     = '0;
      for (int k = 0; k < NCH; k++) begin
         idxInt = int'(r_rr) + k;
         if (idxInt >= NCH) begin
            idxInt = idxInt - NCH;
         end
         idx = CW'(idxInt);
         if (!w_chAny && CH_REQ[idx]) begin
            w_chAny = 1'b1;
            w_chWin = idx;
         end
      end
   end

   // Host wins unless it had the previous slot while a channel is waiting
   always_comb begin
      w_cpuWin = CPU_REQ && (!r_cpuLast || !w_chAny);
      w_rrNext = (w_chWin == CW'(NCH - 1)) ? '0 : w_chWin + 1'b1;
   end

   // State register; reset aborts any access in flight
   always_ff @(posedge CLK or posedge RES) begin
      if (RES) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state logic for the access sequence
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE:    if (CPU_REQ || w_chAny) w_nextState = ADDR;
         ADDR:    w_nextState = ACCESS;
         ACCESS:  if (r_cnt == 4'd0) w_nextState = DONE;
         DONE:    w_nextState = IDLE;
         default: w_nextState = IDLE;
      endcase
   end

   // Grant latching, strobe counter and read-data capture
   always_ff @(posedge CLK or posedge RES) begin
      if (RES) begin
         r_rr       <= '0;
         r_chSel    <= '0;
         r_cpuLast  <= 1'b0;
         r_isCpu    <= 1'b0;
         r_isWrite  <= 1'b0;
         r_cnt      <= 4'd0;
         r_ra       <= '0;
         r_rdOut    <= 8'd0;
         r_chRdata  <= 8'd0;
         r_cpuRdata <= 8'd0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_cpuWin) begin
                  r_isCpu   <= 1'b1;
                  r_isWrite <= CPU_WE;
                  r_ra      <= CPU_ADDR;
                  r_cpuLast <= 1'b1;
                  if (CPU_WE) begin
                     r_rdOut <= CPU_WDATA;
                  end
               end else if (w_chAny) begin
                  r_isCpu   <= 1'b0;
                  r_isWrite <= 1'b0;
                  r_chSel   <= w_chWin;
                  r_ra      <= CH_ADDR[int'(w_chWin)*AW +: AW];
                  r_rr      <= w_rrNext;
                  r_cpuLast <= 1'b0;
               end
            end
            ADDR: begin
               r_cnt <= 4'(ACC_CYC - 1);
            end
            ACCESS: begin
               if (r_cnt == 4'd0) begin
                  if (!r_isWrite) begin
                     if (r_isCpu) begin
                        r_cpuRdata <= RD_IN;
                     end else begin
                        r_chRdata <= RD_IN;
                     end
                  end
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Pad-side and requester-side outputs decoded from the registered state
   always_comb begin
      RA        = r_ra;
      RD_OUT    = r_rdOut;
      RD_OE     = r_isCpu && r_isWrite && (r_state != IDLE);
      NROE      = !((r_state == ACCESS) && !r_isWrite);
      NRWE      = !((r_state == ACCESS) && r_isWrite);
      CPU_ACK   = (r_state == DONE) && r_isCpu;
      CH_ACK    = ((r_state == DONE) && !r_isCpu) ? (NCH'(1) << r_chSel) : '0;
      CH_RDATA  = r_chRdata;
      CPU_RDATA = r_cpuRdata;
      NWAIT     = ~(CPU_REQ & ~CPU_ACK);
   end

endmodule
